// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: buffered write port for the 32x32 register file, forwarding
// pending (queued, not yet written) values onto the decode read ports.  Rev 1.0
`default_nettype none

module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [4:0]    wb_sel,
  input  logic [31:0]   wb_dat,
  input  logic          rf_hold,
  output logic          rf_WEN,
  output logic [4:0]    rf_wsel,
  output logic [31:0]   rf_wdat,
  input  logic [4:0]    rsel1,
  input  logic [4:0]    rsel2,
  output logic [4:0]    rf_rsel1,
  output logic [4:0]    rf_rsel2,
  input  logic [31:0]   rf_rdat1,
  input  logic [31:0]   rf_rdat2,
  output logic [31:0]   rdat1,
  output logic [31:0]   rdat2,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       sel_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];

  logic             enq;
  logic             deq;
  logic [AW-1:0]    head_idx;
  logic [AW-1:0]    tail_idx;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];

  assign count    = CW'(tail_q - head_q);
  assign empty    = (count == '0);
  assign wb_ready = (count != CW'(DEPTH));

  // Writes to r0 complete the handshake but never occupy an entry.
  assign enq      = wb_valid && wb_ready && (wb_sel != 5'd0);
  assign deq      = !empty && !rf_hold;

  assign rf_WEN   = deq;
  assign rf_wsel  = empty ? 5'd0  : sel_q[head_idx];
  assign rf_wdat  = empty ? 32'd0 : dat_q[head_idx];

  assign rf_rsel1 = rsel1;
  assign rf_rsel2 = rsel2;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    if (enq) begin
      tail_d           = tail_q + 1'b1;
      vld_d[tail_idx]  = 1'b1;
    end
    if (deq) begin
      head_d           = head_q + 1'b1;
      vld_d[head_idx]  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      sel_q[tail_idx] <= wb_sel;
      dat_q[tail_idx] <= wb_dat;
    end
  end

  // Scan oldest to youngest so the last match (closest to tail) wins; the
  // head being retired this cycle is still pending until the edge.
  function automatic logic [31:0] fwd(input logic [4:0] rsel, input logic [31:0] rfd);
    logic [31:0]   r;
    logic [AW-1:0] idx;
    r = rfd;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + AW'(i);
      if (vld_q[idx] && (sel_q[idx] == rsel)) begin
        r = dat_q[idx];
      end
    end
    if (rsel == 5'd0) begin
      r = 32'd0;
    end
    return r;
  endfunction

  assign rdat1 = fwd(rsel1, rf_rdat1);
  assign rdat2 = fwd(rsel2, rf_rdat2);

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed checks of rf_writeback_queue (DEPTH=4).
`default_nettype none

module tb_rf_writeback_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        rf_hold;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  rsel1, rsel2;
  logic [4:0]  rf_rsel1, rf_rsel2;
  logic [31:0] rf_rdat1, rf_rdat2;
  logic [31:0] rdat1, rdat2;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] RF1 = 32'hCAFE_0001;
  localparam logic [31:0] RF2 = 32'hCAFE_0002;

  rf_writeback_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_dat(wb_dat),
    .rf_hold(rf_hold), .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rsel1(rsel1), .rsel2(rsel2), .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
    .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2), .rdat1(rdat1), .rdat2(rdat2),
    .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_state(input string tag);
    chk({tag, "_ready"}, wb_ready, 1);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_wen"},   rf_WEN, 0);
    chk({tag, "_wsel"},  rf_wsel, 0);
    chk({tag, "_wdat"},  rf_wdat, 0);
  endtask

  initial begin
    nRST = 1'b0; wb_valid = 1'b0; wb_sel = '0; wb_dat = '0; rf_hold = 1'b0;
    rsel1 = '0; rsel2 = '0; rf_rdat1 = RF1; rf_rdat2 = RF2;

    // Reset and idle
    #12;
    idle_state("in_reset");
    tick();
    nRST = 1'b1;
    tick(); tick();
    idle_state("idle");
    rsel1 = 5'd5; rsel2 = 5'd9; #1;
    chk("idle_rdat1", rdat1, RF1);
    chk("idle_rdat2", rdat2, RF2);
    chk("rsel1_pass", rf_rsel1, 5);
    chk("rsel2_pass", rf_rsel2, 9);

    // Single write: accepted at edge N, written during N+1
    wb_valid = 1'b1; wb_sel = 5'd3; wb_dat = 32'hDEADBEEF; rsel1 = 5'd3;
    tick();
    wb_valid = 1'b0;
    chk("single_count", count, 1);
    chk("single_wen",   rf_WEN, 1);
    chk("single_wsel",  rf_wsel, 3);
    chk("single_wdat",  rf_wdat, 32'hDEADBEEF);
    chk("single_fwd",   rdat1, 32'hDEADBEEF);
    tick();
    chk("single_empty", empty, 1);
    chk("single_after_fwd", rdat1, RF1);

    // Fill under hold
    rf_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wb_valid = 1'b1; wb_sel = 5'(k); wb_dat = 32'(k * 'h11);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_ready", wb_ready, 0);
    chk("full_wen",   rf_WEN, 0);
    wb_sel = 5'd5; wb_dat = 32'h55;
    tick();
    wb_valid = 1'b0;
    chk("full_reject_count", count, 4);
    rsel1 = 5'd5; rsel2 = 5'd2; #1;
    chk("full_reject_fwd", rdat1, RF1);
    chk("full_fwd2", rdat2, 32'h22);
    rf_hold = 1'b0; #1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_wen",  rf_WEN, 1);
      chk("drain_wsel", rf_wsel, 5'(k));
      chk("drain_wdat", rf_wdat, 32'(k * 'h11));
      tick();
    end
    chk("drain_empty", empty, 1);

    // Forwarding priority: youngest of two entries to r7 wins
    rf_hold = 1'b1; rf_rdat1 = 32'hFF;
    wb_valid = 1'b1; wb_sel = 5'd7; wb_dat = 32'hA; tick();
    wb_dat = 32'hB; tick();
    wb_dat = 32'hC;
    rsel1 = 5'd7; rsel2 = 5'd8; #1;
    chk("fwd_youngest", rdat1, 32'hB);
    chk("fwd_miss2", rdat2, RF2);
    rsel1 = 5'd0; #1;
    chk("fwd_r0", rdat1, 0);
    rsel1 = 5'd7;
    wb_valid = 1'b0; rf_hold = 1'b0; #1;
    chk("fwd_retire_wdat", rf_wdat, 32'hA);
    chk("fwd_during_retire", rdat1, 32'hB);
    tick();
    chk("fwd_retire2_wdat", rf_wdat, 32'hB);
    chk("fwd_last_pending", rdat1, 32'hB);
    tick();
    chk("fwd_done_empty", empty, 1);
    chk("fwd_done_rdat1", rdat1, 32'hFF);

    // Simultaneous enqueue and retire keeps count steady
    wb_valid = 1'b1; wb_sel = 5'd9; wb_dat = 32'h99; tick();
    wb_sel = 5'd10; wb_dat = 32'hAA; #1;
    chk("simul_pre_wsel", rf_wsel, 9);
    tick();
    wb_valid = 1'b0;
    chk("simul_count", count, 1);
    chk("simul_wsel", rf_wsel, 10);
    chk("simul_wdat", rf_wdat, 32'hAA);
    tick();
    chk("simul_empty", empty, 1);

    // Register 0: handshake completes, nothing queued
    wb_valid = 1'b1; wb_sel = 5'd0; wb_dat = 32'h1234; #1;
    chk("r0_ready", wb_ready, 1);
    tick();
    wb_valid = 1'b0;
    chk("r0_count", count, 0);
    chk("r0_wen", rf_WEN, 0);
    tick();
    chk("r0_wen2", rf_WEN, 0);

    // Reset mid-operation discards pending entries
    rf_hold = 1'b1;
    for (int k = 4; k <= 6; k++) begin
      wb_valid = 1'b1; wb_sel = 5'(k); wb_dat = 32'(k); tick();
    end
    wb_valid = 1'b0;
    chk("mid_count", count, 3);
    #2 nRST = 1'b0;
    #1;
    idle_state("mid_reset");
    rf_hold = 1'b0; #1;
    chk("mid_reset_wen", rf_WEN, 0);
    #1 nRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_reset_wen", rf_WEN, 0);
    end
    chk("post_reset_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
